// File: rtl/procesador_pkg.sv
// Shared definitions for the processor control path: sequencer states,
// opcode constants and algorithm indices.
package procesador_pkg;

    // Sequencer states of the instruction-fetch consumer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        JUMP  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    // Opcodes with special meaning to the sequencer
    localparam logic [3:0] OP_END = 4'b1111;
    localparam logic [3:0] OP_NOP = 4'b0000;

    // Algorithm indices as presented on alg_sel / sel_dir
    localparam logic [2:0] ENC_XOR    = 3'd0;
    localparam logic [2:0] DEC_XOR    = 3'd1;
    localparam logic [2:0] ENC_SHIFT  = 3'd2;
    localparam logic [2:0] DEC_SHIFT  = 3'd3;
    localparam logic [2:0] ENC_CSHIFT = 3'd4;
    localparam logic [2:0] DEC_CSHIFT = 3'd5;
    localparam logic [2:0] ENC_ADD    = 3'd6;
    localparam logic [2:0] DEC_ADD    = 3'd7;

    // Instruction width and run-length counter width
    localparam int INSTR_W = 14;
    localparam int COUNT_W = 10;

endpackage

// File: rtl/contador_squash.sv
// Loadable down-counter that times how many stale fetch words are discarded
// after a jump. The zero flag looks at the value the counter takes at the
// coming edge, so the sequencer can leave FLUSH exactly when the entry word
// becomes visible on the fetch bus.
module contador_squash #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement, decrement saturates at zero
    always_comb begin
        // NOTE: count_d is assigned a default before any branch so that no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignment so every flop samples values from before the edge, independent of statement order.
            count_q <= count_d;
        end
    end

    assign zero = (count_d == '0);

endmodule

// File: rtl/control_if.sv
// Sequencer on the consuming side of the instruction-fetch stage: jumps the
// fetch stage to an algorithm's entry address, discards the words already in
// flight, then issues instructions to decode until END, timeout or abort.
module control_if
    import procesador_pkg::*;
#(
    parameter int FETCH_LAT = 2,
    parameter int MAX_INSTR = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [2:0]          alg_sel,
    input  logic [INSTR_W-1:0]  instruccion,
    input  logic [3:0]          opcode,
    output logic [2:0]          sel_dir,
    output logic                sel_pc,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr_id,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [COUNT_W-1:0]  instr_count
);

    localparam int                 SQ_W     = $clog2(FETCH_LAT + 1);
    localparam logic [SQ_W-1:0]    SQ_LOAD  = SQ_W'(FETCH_LAT);
    localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_INSTR);

    state_t               state_q, state_d;
    logic [2:0]           sel_dir_q, sel_dir_d;
    logic                 instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0]   instr_id_q, instr_id_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic                 start_ok;
    logic                 sq_dec;
    logic                 sq_zero;

    // A start is accepted only from IDLE and only when abort is low. The
    // squash counter is loaded on that edge and counts down through JUMP and
    // FLUSH, so it hits zero as the entry word reaches instruccion.
    assign start_ok = (state_q == IDLE) && start && !abort;
    assign sq_dec   = (state_q == JUMP) || (state_q == FLUSH);

    contador_squash #(
        .W (SQ_W)
    ) u_squash (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_ok),
        .dec      (sq_dec),
        .load_val (SQ_LOAD),
        .zero     (sq_zero)
    );

    // Next-state and next-output logic of the sequencer
    always_comb begin
        state_d       = state_q;
        sel_dir_d     = sel_dir_q;
        instr_valid_d = 1'b0;
        instr_id_d    = instr_id_q;
        done_d        = 1'b0;
        error_d       = error_q;
        count_d       = count_q;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    sel_dir_d = alg_sel;
                    error_d   = 1'b0;
                    count_d   = '0;
                    state_d   = JUMP;
                end
            end
            JUMP: begin
                state_d = abort ? IDLE : FLUSH;
            end
            FLUSH: begin
                // Words on instruccion are stale here and are not looked at
                if (abort) begin
                    state_d = IDLE;
                end else if (sq_zero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (opcode == OP_END) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (count_q == MAX_CNT) begin
                    // Runaway algorithm: the limit is reached without END
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Bubbles are forwarded but flagged invalid and not counted
                    instr_id_d = instruccion;
                    if (opcode != OP_NOP) begin
                        instr_valid_d = 1'b1;
                        count_d       = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_dir_q     <= '0;
            instr_valid_q <= 1'b0;
            instr_id_q    <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            sel_dir_q     <= sel_dir_d;
            instr_valid_q <= instr_valid_d;
            instr_id_q    <= instr_id_d;
            done_q        <= done_d;
            error_q       <= error_d;
            count_q       <= count_d;
        end
    end

    assign sel_dir     = sel_dir_q;
    assign sel_pc      = (state_q == JUMP);
    assign busy        = (state_q != IDLE);
    assign instr_valid = instr_valid_q;
    assign instr_id    = instr_id_q;
    assign done        = done_q;
    assign error       = error_q;
    assign instr_count = count_q;

endmodule
